// File: rtl/edm_pkg.sv
// Shared definitions for the EDM servo blocks.
// Holds the rate width, the gap-servo FSM state encoding and the
// Z-axis direction encoding so that producer/consumer blocks agree.
package edm_pkg;

  // Width of every pulse-class rate coming from pulse_statistic.
  localparam int unsigned RATE_W = 8;

  // Width of the per-decision step counter (1..255 steps).
  localparam int unsigned STEP_CNT_W = 8;

  // Direction encoding on the stepper dir line.
  localparam logic DIR_ADVANCE = 1'b1;
  localparam logic DIR_RETRACT = 1'b0;

  // Gap-servo controller states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WINDOW  = 3'd1,
    S_DECIDE  = 3'd2,
    S_STEP_HI = 3'd3,
    S_STEP_LO = 3'd4,
    S_FINISH  = 3'd5
  } servo_state_e;

endpackage

// File: rtl/servo_decide.sv
// Combinational move selection for the gap servo.
// Looks at the four pulse-class rates and picks a direction and a step
// count. Priority (first match wins): short, arc, open, normal, creep.
// Ports:
//   normal_rate_i, arc_rate_i, open_rate_i, short_rate_i : rates, unsigned
//   dir_o   : chosen direction (only meaningful when n_o != 0)
//   n_o     : number of steps to issue, 0 means hold position
module servo_decide
  import edm_pkg::*;
#(
  parameter logic [RATE_W-1:0]     SHORT_TH      = 8'd64,
  parameter logic [RATE_W-1:0]     ARC_TH        = 8'd32,
  parameter logic [RATE_W-1:0]     OPEN_TH       = 8'd128,
  parameter logic [RATE_W-1:0]     NORMAL_TH     = 8'd160,
  parameter logic [STEP_CNT_W-1:0] RETRACT_STEPS = 8'd8,
  parameter logic [STEP_CNT_W-1:0] ADVANCE_STEPS = 8'd4
) (
  input  logic [RATE_W-1:0]     normal_rate_i,
  input  logic [RATE_W-1:0]     arc_rate_i,
  input  logic [RATE_W-1:0]     open_rate_i,
  input  logic [RATE_W-1:0]     short_rate_i,
  output logic                  dir_o,
  output logic [STEP_CNT_W-1:0] n_o
);

  // Shorts and arcs both mean the electrode is too close, so they back off.
  // An open gap means too far, so advance quickly. A healthy normal rate
  // holds. Anything else creeps forward one step to close the gap slowly.
  always_comb begin
    dir_o = DIR_ADVANCE;
    n_o   = STEP_CNT_W'(1);
    if (short_rate_i >= SHORT_TH) begin
      dir_o = DIR_RETRACT;
      n_o   = RETRACT_STEPS;
    end else if (arc_rate_i >= ARC_TH) begin
      dir_o = DIR_RETRACT;
      n_o   = RETRACT_STEPS;
    end else if (open_rate_i >= OPEN_TH) begin
      dir_o = DIR_ADVANCE;
      n_o   = ADVANCE_STEPS;
    end else if (normal_rate_i >= NORMAL_TH) begin
      dir_o = DIR_ADVANCE;
      n_o   = '0;
    end
  end

endmodule

// File: rtl/gap_servo_ctrl.sv
// Closed-loop EDM gap servo controller.
// Every UPDATE_PERIOD cycles it snapshots the pulse-class rates, chooses a
// move via servo_decide, plays the step train to the Z stepper driver and
// then pulses feedback_finished so pulse_statistic restarts its window.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   is_machine         : machining enable, low returns to IDLE
//   *_pulse_rate       : pulse-class rates from pulse_statistic
//   feedback_finished  : one-cycle pulse after a decision has been executed
//   step, dir          : stepper interface (dir 1 = advance)
//   servo_busy         : high while a decision is being taken/executed
module gap_servo_ctrl
  import edm_pkg::*;
#(
  parameter int unsigned           UPDATE_PERIOD = 100000,
  parameter int unsigned           STEP_HALF     = 500,
  parameter logic [RATE_W-1:0]     SHORT_TH      = 8'd64,
  parameter logic [RATE_W-1:0]     ARC_TH        = 8'd32,
  parameter logic [RATE_W-1:0]     OPEN_TH       = 8'd128,
  parameter logic [RATE_W-1:0]     NORMAL_TH     = 8'd160,
  parameter logic [STEP_CNT_W-1:0] RETRACT_STEPS = 8'd8,
  parameter logic [STEP_CNT_W-1:0] ADVANCE_STEPS = 8'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_machine,
  input  logic [RATE_W-1:0] normal_pulse_rate,
  input  logic [RATE_W-1:0] arc_pulse_rate,
  input  logic [RATE_W-1:0] open_pulse_rate,
  input  logic [RATE_W-1:0] short_pulse_rate,
  output logic              feedback_finished,
  output logic              step,
  output logic              dir,
  output logic              servo_busy
);

  localparam int unsigned WIN_W  = $clog2(UPDATE_PERIOD);
  localparam int unsigned HALF_W = (STEP_HALF > 1) ? $clog2(STEP_HALF) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(UPDATE_PERIOD - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(STEP_HALF - 1);

  servo_state_e            state_q, state_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [HALF_W-1:0]       half_q, half_d;
  logic [STEP_CNT_W-1:0]   steps_q, steps_d;
  logic                    dir_q, dir_d;

  logic                    dec_dir;
  logic [STEP_CNT_W-1:0]   dec_n;

  servo_decide #(
    .SHORT_TH      (SHORT_TH),
    .ARC_TH        (ARC_TH),
    .OPEN_TH       (OPEN_TH),
    .NORMAL_TH     (NORMAL_TH),
    .RETRACT_STEPS (RETRACT_STEPS),
    .ADVANCE_STEPS (ADVANCE_STEPS)
  ) u_decide (
    .normal_rate_i (normal_pulse_rate),
    .arc_rate_i    (arc_pulse_rate),
    .open_rate_i   (open_pulse_rate),
    .short_rate_i  (short_pulse_rate),
    .dir_o         (dec_dir),
    .n_o           (dec_n)
  );

  // State and counter registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      half_q  <= '0;
      steps_q <= '0;
      dir_q   <= DIR_RETRACT;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      half_q  <= half_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic. The decision outputs are only captured in DECIDE,
  // so rate changes while the train is running have no effect. A hold
  // decision leaves dir untouched so the stepper line does not toggle.
  // Dropping is_machine abandons whatever is in flight; the outputs are
  // pure state decodes, so a step pulse already high ends on a clock edge.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    half_d  = half_q;
    steps_d = steps_q;
    dir_d   = dir_q;

    if (!is_machine) begin
      state_d = S_IDLE;
      win_d   = '0;
      half_d  = '0;
      steps_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WINDOW;
          win_d   = '0;
        end
        S_WINDOW: begin
          if (win_q == WIN_LAST) begin
            state_d = S_DECIDE;
            win_d   = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end
        S_DECIDE: begin
          half_d = '0;
          if (dec_n == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_STEP_HI;
            dir_d   = dec_dir;
            steps_d = dec_n;
          end
        end
        S_STEP_HI: begin
          if (half_q == HALF_LAST) begin
            state_d = S_STEP_LO;
            half_d  = '0;
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end
        S_STEP_LO: begin
          if (half_q == HALF_LAST) begin
            half_d = '0;
            if (steps_q == STEP_CNT_W'(1)) begin
              state_d = S_FINISH;
              steps_d = '0;
            end else begin
              state_d = S_STEP_HI;
              steps_d = steps_q - STEP_CNT_W'(1);
            end
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end
        S_FINISH: begin
          state_d = S_WINDOW;
          win_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign step              = (state_q == S_STEP_HI);
  assign feedback_finished = (state_q == S_FINISH);
  assign dir               = dir_q;
  assign servo_busy        = (state_q == S_DECIDE)  || (state_q == S_STEP_HI) ||
                             (state_q == S_STEP_LO) || (state_q == S_FINISH);

endmodule

// File: tb/tb_gap_servo_ctrl.sv
// Self-checking bench for gap_servo_ctrl with a short window and short
// step half-period. Expected decisions are queued when rates are applied
// and compared against what a monitor observes on the stepper lines.
module tb_gap_servo_ctrl;

  localparam int UPDATE_PERIOD = 100;
  localparam int STEP_HALF     = 5;

  logic       clk;
  logic       rst;
  logic       isMachine;
  logic [7:0] normalRate, arcRate, openRate, shortRate;
  logic       feedbackFinished, step, dir, servoBusy;

  gap_servo_ctrl #(
    .UPDATE_PERIOD (UPDATE_PERIOD),
    .STEP_HALF     (STEP_HALF)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .is_machine        (isMachine),
    .normal_pulse_rate (normalRate),
    .arc_pulse_rate    (arcRate),
    .open_pulse_rate   (openRate),
    .short_pulse_rate  (shortRate),
    .feedback_finished (feedbackFinished),
    .step              (step),
    .dir               (dir),
    .servo_busy        (servoBusy)
  );

  typedef struct {
    int   decideCyc;
    int   firstRise;
    int   finishCyc;
    int   nSteps;
    bit   widthsOk;
    bit   dirStable;
    logic dirFirst;
    logic dirAtFinish;
  } obsT;

  typedef struct {
    int   nSteps;
    logic dir;
    int   refCyc;
  } expT;

  obsT obsQ[$];
  expT expQ[$];

  int cyc        = 0;
  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int fbCount    = 0;

  // Rate table and hand-derived decisions (n steps, direction).
  int tShort [12] = '{80, 0,   0,   0, 64, 0,   63, 0,   63,  80,  80, 0};
  int tArc   [12] = '{0,  0,   0,   0, 0,  0,   32, 31,  31,  40,  0,  0};
  int tOpen  [12] = '{0,  200, 0,   0, 0,  0,   0,  128, 127, 200, 0,  200};
  int tNormal[12] = '{0,  0,   200, 0, 0,  160, 0,  0,   159, 200, 0,  0};
  int tN     [12] = '{8,  4,   0,   1, 8,  0,   8,  4,   1,   8,   8,  4};
  bit tDir   [12] = '{0,  1,   1,   1, 0,  0,   0,  1,   1,   0,   0,  1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reconstructs each decision from the output lines.
  obsT  cur;
  logic prevStep = 1'b0;
  logic prevBusy = 1'b0;
  int   hiLen    = 0;
  int   loLen    = 0;
  bit   loActive = 1'b0;

  initial begin
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStep = 1'b0;
        prevBusy = 1'b0;
        loActive = 1'b0;
      end else begin
        if (servoBusy && !prevBusy) begin
          cur.decideCyc = cyc;
          cur.firstRise = -1;
          cur.finishCyc = -1;
          cur.nSteps    = 0;
          cur.widthsOk  = 1'b1;
          cur.dirStable = 1'b1;
          cur.dirFirst  = dir;
          loActive      = 1'b0;
        end
        if (feedbackFinished) begin
          fbCount++;
          if (loActive && loLen != STEP_HALF) cur.widthsOk = 1'b0;
          loActive        = 1'b0;
          cur.finishCyc   = cyc;
          cur.dirAtFinish = dir;
          obsQ.push_back(cur);
        end
        if (step && !prevStep) begin
          if (loActive && loLen != STEP_HALF) cur.widthsOk = 1'b0;
          loActive = 1'b0;
          cur.nSteps++;
          if (cur.firstRise < 0) begin
            cur.firstRise = cyc;
            cur.dirFirst  = dir;
          end
          hiLen = 1;
        end else if (step) begin
          hiLen++;
        end else if (prevStep) begin
          if (hiLen != STEP_HALF) cur.widthsOk = 1'b0;
          loActive = 1'b1;
          loLen    = 1;
        end else if (loActive) begin
          loLen++;
        end
        if (step && dir !== cur.dirFirst) cur.dirStable = 1'b0;
        prevStep = step;
        prevBusy = servoBusy;
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit pushExp, input int refAt);
    expT e;
    shortRate  = 8'(tShort[idx]);
    arcRate    = 8'(tArc[idx]);
    openRate   = 8'(tOpen[idx]);
    normalRate = 8'(tNormal[idx]);
    if (pushExp) begin
      e.nSteps = tN[idx];
      e.dir    = tDir[idx];
      e.refCyc = refAt;
      expQ.push_back(e);
    end
  endtask

  task automatic waitBusyRise(output bit ok);
    logic prev;
    prev = servoBusy;
    ok   = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (servoBusy && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = servoBusy;
    end
  endtask

  task automatic waitObs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (obsQ.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pops one observed decision and its expectation and compares them.
  task automatic scoreDecision(input int idx);
    bit  ok;
    obsT o;
    expT e;
    int  expDecide, expFinish;
    waitObs(ok);
    checkOutput($sformatf("decision%0d_arrived", idx), int'(ok), 1);
    if (ok && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      expDecide = e.refCyc + UPDATE_PERIOD + 1;
      expFinish = expDecide + 1 + e.nSteps * 2 * STEP_HALF;
      checkOutput($sformatf("decision%0d_decide_cycle", idx), o.decideCyc, expDecide);
      checkOutput($sformatf("decision%0d_steps", idx), o.nSteps, e.nSteps);
      checkOutput($sformatf("decision%0d_finish_cycle", idx), o.finishCyc, expFinish);
      checkOutput($sformatf("decision%0d_dir_after", idx), int'(o.dirAtFinish), int'(e.dir));
      if (e.nSteps > 0) begin
        checkOutput($sformatf("decision%0d_first_rise", idx), o.firstRise - o.decideCyc, 1);
        checkOutput($sformatf("decision%0d_dir", idx), int'(o.dirFirst), int'(e.dir));
        checkOutput($sformatf("decision%0d_dir_stable", idx), int'(o.dirStable), 1);
        checkOutput($sformatf("decision%0d_widths", idx), int'(o.widthsOk), 1);
      end
    end
  endtask

  initial begin
    bit   ok;
    int   refCyc, nextRef, rises, fbBefore;
    logic prevS;

    rst        = 1'b1;
    isMachine  = 1'b0;
    normalRate = 8'd0;
    arcRate    = 8'd0;
    openRate   = 8'd0;
    shortRate  = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_step", int'(step), 0);
    checkOutput("reset_dir", int'(dir), 0);
    checkOutput("reset_feedback", int'(feedbackFinished), 0);
    checkOutput("reset_busy", int'(servoBusy), 0);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_without_enable_busy", int'(servoBusy), 0);

    // Directed decisions; next rates are applied while the current train runs
    refCyc    = cyc;
    isMachine = 1'b1;
    applyStimulus(0, 1'b1, refCyc);
    for (int k = 0; k < 10; k++) begin
      waitBusyRise(ok);
      checkOutput($sformatf("decision%0d_busy_rise", k), int'(ok), 1);
      @(negedge clk);
      nextRef = refCyc + UPDATE_PERIOD + 2 + tN[k] * 2 * STEP_HALF;
      applyStimulus(k + 1, (k < 9), nextRef);
      scoreDecision(k);
      refCyc = nextRef;
    end

    // Drop enable during the third step high phase
    waitBusyRise(ok);
    checkOutput("drop_busy_rise", int'(ok), 1);
    rises = 0;
    prevS = step;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (step && !prevS) rises++;
      prevS = step;
      if (rises == 3) break;
    end
    checkOutput("drop_third_step_seen", rises, 3);
    fbBefore  = fbCount;
    isMachine = 1'b0;
    @(negedge clk);
    checkOutput("drop_step_low", int'(step), 0);
    checkOutput("drop_busy_low", int'(servoBusy), 0);
    checkOutput("drop_feedback_low", int'(feedbackFinished), 0);
    repeat (20) @(negedge clk);
    checkOutput("drop_no_feedback", fbCount, fbBefore);
    checkOutput("drop_no_decision", obsQ.size(), 0);

    // Restore enable: a full window must elapse before the next decision
    refCyc    = cyc;
    isMachine = 1'b1;
    applyStimulus(10, 1'b1, refCyc);
    waitBusyRise(ok);
    checkOutput("restore_busy_rise", int'(ok), 1);
    @(negedge clk);
    applyStimulus(11, 1'b0, 0);
    scoreDecision(10);

    // Reset during the first low phase of an advance train
    waitBusyRise(ok);
    checkOutput("rst_busy_rise", int'(ok), 1);
    ok    = 1'b0;
    prevS = step;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prevS && !step) begin
        ok = 1'b1;
        break;
      end
      prevS = step;
    end
    checkOutput("rst_step_lo_reached", int'(ok), 1);
    checkOutput("rst_dir_before", int'(dir), int'(tDir[11]));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_step", int'(step), 0);
    checkOutput("rst_mid_dir", int'(dir), 0);
    checkOutput("rst_mid_feedback", int'(feedbackFinished), 0);
    checkOutput("rst_mid_busy", int'(servoBusy), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
